// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM
// states, default address width and the request legality check.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 9;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // Misaligned halfword/word accesses and the unused size code are rejected.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling between the word-wide memory and the
// byte/half/word requests: load extraction with extension, store merge.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] read_data_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pure lane steering; both results are consumed only in the RD state.
  always_comb begin
    load_data_o  = extract(read_data_i, offset_i, size_i, unsigned_i);
    store_data_o = merge(read_data_i, wdata_i, offset_i, size_i);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the word-wide data memory: one load/store in flight,
// sub-word stores done as read-modify-write, all memory outputs registered.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;

  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [31:0] load_data;
  logic [31:0] merge_data;

  lane_align u_lane_align (
    .read_data_i  (read_data),
    .wdata_i      (st_data_q),
    .offset_i     (off_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .load_data_o  (load_data),
    .store_data_o (merge_data)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign req_ready  = (state_q == IDLE) && rst_n;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign MemRead    = mem_rd_q;
  assign MemWrite   = mem_wr_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;

  // Next state and next registered outputs: outputs are computed for the
  // state being entered, so MemRead/MemWrite/resp_valid line up with RD/WR/RESP.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    st_data_d    = st_data_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          size_d    = req_size;
          uns_d     = req_unsigned;
          off_d     = req_addr[1:0];
          st_data_d = req_wdata;
          if (is_bad_req(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_d  = WR;
            mem_wr_d = 1'b1;
            addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d  = req_wdata;
          end else begin
            state_d  = RD;
            mem_rd_d = 1'b1;
            addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d  = WR;
          mem_wr_d = 1'b1;
          wdata_d  = merge_data;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs; async reset aborts any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      st_data_q    <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      st_data_q    <= st_data_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  logic [31:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  mem_access_unit #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  assign read_data = mem[addr[8:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[addr[8:2]] <= write_data;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  always @(negedge clk) if (MemRead && MemWrite) overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request, then records memory activity until resp_valid (bounded).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [8:0] a, input logic [31:0] wd,
                        output int lat, output int nrd, output int nwr,
                        output logic [31:0] rd, output logic err,
                        output logic [31:0] wseen, output logic [8:0] aseen);
    int w;
    lat = 0; nrd = 0; nwr = 0; rd = '0; err = 1'b0; wseen = '0; aseen = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
    req_addr = ~a; req_wdata = ~wd;
    for (int k = 1; k <= 8; k++) begin
      if (MemRead) begin nrd++; aseen = addr; end
      if (MemWrite) begin nwr++; wseen = write_data; aseen = addr; end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [8:0] a, input logic [31:0] exp);
    int lat, nrd, nwr;
    logic [31:0] rd, ws;
    logic err;
    logic [8:0] as;
    do_req(1'b0, sz, uns, a, 32'h0, lat, nrd, nwr, rd, err, ws, as);
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_nrd"}, nrd, 32'd1);
    chk({tag, "_nwr"}, nwr, 32'd0);
    chk({tag, "_addr"}, {23'd0, as}, {23'd0, a[8:2], 2'b00});
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic run_store(input string tag, input logic [1:0] sz, input logic [8:0] a,
                           input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_w);
    int lat, nrd, nwr;
    logic [31:0] rd, ws;
    logic err;
    logic [8:0] as;
    do_req(1'b1, sz, 1'b0, a, wd, lat, nrd, nwr, rd, err, ws, as);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_nrd"}, nrd, (exp_lat == 3) ? 32'd1 : 32'd0);
    chk({tag, "_nwr"}, nwr, 32'd1);
    chk({tag, "_wdata"}, ws, exp_w);
    chk({tag, "_addr"}, {23'd0, as}, {23'd0, a[8:2], 2'b00});
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic run_err(input string tag, input logic we, input logic [1:0] sz, input logic [8:0] a);
    int lat, nrd, nwr;
    logic [31:0] rd, ws;
    logic err;
    logic [8:0] as;
    do_req(we, sz, 1'b0, a, 32'hFFFF_FFFF, lat, nrd, nwr, rd, err, ws, as);
    chk({tag, "_lat"}, lat, 32'd1);
    chk({tag, "_nrd"}, nrd, 32'd0);
    chk({tag, "_nwr"}, nwr, 32'd0);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
  endtask

  initial begin
    logic [2:0] pat;
    logic [2:0] exp_pat [0:4];
    logic [31:0] w0, w3;
    logic [8:0] a3;
    int w;
    int seen_rv, seen_mw;

    exp_pat[0] = 3'b010; exp_pat[1] = 3'b001; exp_pat[2] = 3'b100;
    exp_pat[3] = 3'b010; exp_pat[4] = 3'b001;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_memread", {31'd0, MemRead}, 32'd0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_addr", {23'd0, addr}, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Word load
    preload(7'd4, 32'h44332211);
    run_load("lw", SZ_WORD, 1'b0, 9'h010, 32'h44332211);

    // Byte and halfword loads with sign/zero extension
    preload(7'd4, 32'h80332211);
    run_load("lb", SZ_BYTE, 1'b0, 9'h013, 32'hFFFFFF80);
    run_load("lbu", SZ_BYTE, 1'b1, 9'h013, 32'h00000080);
    run_load("lh", SZ_HALF, 1'b0, 9'h012, 32'hFFFF8033);
    run_load("lhu", SZ_HALF, 1'b1, 9'h012, 32'h00008033);
    run_load("lbu0", SZ_BYTE, 1'b1, 9'h010, 32'h00000011);

    // Sub-word stores via read-modify-write
    preload(7'd4, 32'h44332211);
    run_store("sb", SZ_BYTE, 9'h011, 32'hDEADBEAB, 3, 32'h4433AB11);
    run_load("lw_after_sb", SZ_WORD, 1'b0, 9'h010, 32'h4433AB11);
    run_store("sh", SZ_HALF, 9'h012, 32'h1234CAFE, 3, 32'hCAFEAB11);
    chk("mem4_after_sh", mem[4], 32'hCAFEAB11);

    // Misaligned and illegal requests
    run_err("lh_mis", 1'b0, SZ_HALF, 9'h011);
    run_err("lw_mis", 1'b0, SZ_WORD, 9'h012);
    run_err("sw_mis", 1'b1, SZ_WORD, 9'h013);
    run_err("sz11", 1'b0, 2'b11, 9'h010);
    chk("mem4_after_err", mem[4], 32'hCAFEAB11);

    // Back-to-back word stores with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 9'h020; req_wdata = 32'h11111111;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    if (!req_ready) chk("b2b_ready_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_addr = 9'h024; req_wdata = 32'h22222222;
    w0 = '0; w3 = '0; a3 = '0;
    for (int k = 0; k < 5; k++) begin
      pat = {req_ready, MemWrite, resp_valid};
      chk($sformatf("b2b_pat%0d", k), {29'd0, pat}, {29'd0, exp_pat[k]});
      if (k == 0) w0 = write_data;
      if (k == 3) begin w3 = write_data; a3 = addr; end
      if (k < 4) begin @(posedge clk); #1; end
    end
    req_valid = 1'b0;
    chk("b2b_wdata0", w0, 32'h11111111);
    chk("b2b_wdata1", w3, 32'h22222222);
    chk("b2b_addr1", {23'd0, a3}, 32'h024);
    chk("b2b_mem8", mem[8], 32'h11111111);
    chk("b2b_mem9", mem[9], 32'h22222222);
    run_load("lw_b2b", SZ_WORD, 1'b0, 9'h024, 32'h22222222);

    // Reset during the RD phase of a byte store
    preload(7'd5, 32'h55667788);
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 9'h014; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rrd_memread_before", {31'd0, MemRead}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rrd_memread", {31'd0, MemRead}, 32'd0);
    chk("rrd_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rrd_addr", {23'd0, addr}, 32'd0);
    chk("rrd_wdata", write_data, 32'd0);
    chk("rrd_rvalid", {31'd0, resp_valid}, 32'd0);
    seen_rv = 0; seen_mw = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen_rv++;
      if (MemWrite) seen_mw++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen_rv++;
      if (MemWrite) seen_mw++;
    end
    chk("rrd_no_resp", seen_rv, 32'd0);
    chk("rrd_no_write", seen_mw, 32'd0);
    chk("rrd_mem5", mem[5], 32'h55667788);
    run_load("lw_after_rst", SZ_WORD, 1'b0, 9'h014, 32'h55667788);

    chk("rd_wr_overlap", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
